// File: rtl/store_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : store_monitor_if
// Brief    : Core store bus plus verdict/status and store-log read side.
// Revision : 1.0
// ============================================================================
interface store_monitor_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;
  logic [31:0] cycle_count;
  logic [15:0] store_count;
  logic        log_pop;
  logic        log_valid;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic        log_overflow;

  modport master (
    output MemWrite, DataAdr, WriteData, log_pop,
    input  done, pass, fail_code, cycle_count, store_count,
    input  log_valid, log_addr, log_data, log_overflow
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData, log_pop,
    output done, pass, fail_code, cycle_count, store_count,
    output log_valid, log_addr, log_data, log_overflow
  );
endinterface
`default_nettype wire

// File: rtl/store_monitor.sv
`default_nettype none
// ============================================================================
// Module   : store_monitor
// Brief    : Watches core stores and declares pass/fail/timeout; optional
//            FIFO log of accepted stores enabled by STORE_MONITOR_LOG_EN.
// Revision : 1.0
// ============================================================================
module store_monitor #(
  parameter logic [31:0] PASS_ADDR    = 32'd100,
  parameter logic [31:0] PASS_DATA    = 32'd25,
  parameter logic [31:0] SCRATCH_ADDR = 32'd96,
  parameter int          TIMEOUT      = 2000,
  parameter int          LOG_DEPTH    = 8
) (
  input  logic            clk,
  input  logic            reset,
  store_monitor_if.slave  bus
);

  localparam logic [1:0] c_st_run   = 2'd0;
  localparam logic [1:0] c_st_pass  = 2'd1;
  localparam logic [1:0] c_st_fail  = 2'd2;

  localparam logic [1:0] c_fc_none    = 2'd0;
  localparam logic [1:0] c_fc_addr    = 2'd1;
  localparam logic [1:0] c_fc_data    = 2'd2;
  localparam logic [1:0] c_fc_timeout = 2'd3;

  localparam logic [31:0] c_timeout_last = 32'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [1:0]  r_fail_code;
  logic [1:0]  w_fail_code_nxt;
  logic        r_done;
  logic        r_pass;
  logic [31:0] r_cycle_count;
  logic [15:0] r_store_count;
  logic        w_run;
  logic        w_store;

  assign w_run   = (r_state == c_st_run);
  assign w_store = w_run & bus.MemWrite;

  // A terminating store outranks the timeout on the same cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_fail_code_nxt = r_fail_code;
    if (w_run) begin
      if (w_store && (bus.DataAdr == PASS_ADDR)) begin
        if (bus.WriteData == PASS_DATA) begin
          w_state_nxt = c_st_pass;
        end else begin
          w_state_nxt     = c_st_fail;
          w_fail_code_nxt = c_fc_data;
        end
      end else if (w_store && (bus.DataAdr != SCRATCH_ADDR)) begin
        w_state_nxt     = c_st_fail;
        w_fail_code_nxt = c_fc_addr;
      end else if (r_cycle_count == c_timeout_last) begin
        w_state_nxt     = c_st_fail;
        w_fail_code_nxt = c_fc_timeout;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= c_st_run;
      r_fail_code   <= c_fc_none;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_cycle_count <= '0;
      r_store_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_fail_code <= w_fail_code_nxt;
      r_done      <= (w_state_nxt != c_st_run);
      r_pass      <= (w_state_nxt == c_st_pass);
      if (w_run) begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end
      if (w_store && (r_store_count != 16'hFFFF)) begin
        r_store_count <= r_store_count + 16'd1;
      end
    end
  end

  assign bus.done        = r_done;
  assign bus.pass        = r_pass;
  assign bus.fail_code   = r_fail_code;
  assign bus.cycle_count = r_cycle_count;
  assign bus.store_count = r_store_count;

`ifdef STORE_MONITOR_LOG_EN
  localparam int c_aw = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
  localparam logic [c_aw:0] c_depth = (c_aw + 1)'(LOG_DEPTH);

  logic [31:0]   r_mem_addr [LOG_DEPTH];
  logic [31:0]   r_mem_data [LOG_DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0] r_log_count;
  logic          r_log_overflow;
  logic          w_log_empty;
  logic          w_log_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  assign w_log_empty = (r_log_count == '0);
  assign w_log_full  = (r_log_count == c_depth);
  assign w_pop       = bus.log_pop & ~w_log_empty;
  // When full, a concurrent pop frees the slot the push lands in.
  assign w_push      = w_store & (~w_log_full | w_pop);
  assign w_drop      = w_store & w_log_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= bus.DataAdr;
      r_mem_data[r_wr_ptr] <= bus.WriteData;
    end
  end

  // Pointers are c_aw bits wide, so they wrap modulo the power-of-two depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_log_count    <= '0;
      r_log_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_log_count <= r_log_count + 1'b1;
        2'b01:   r_log_count <= r_log_count - 1'b1;
        default: r_log_count <= r_log_count;
      endcase
      if (w_drop) begin
        r_log_overflow <= 1'b1;
      end
    end
  end

  assign bus.log_valid    = ~w_log_empty;
  assign bus.log_addr     = w_log_empty ? 32'd0 : r_mem_addr[r_rd_ptr];
  assign bus.log_data     = w_log_empty ? 32'd0 : r_mem_data[r_rd_ptr];
  assign bus.log_overflow = r_log_overflow;
`else
  logic w_unused_log_pop;
  assign w_unused_log_pop = bus.log_pop;

  assign bus.log_valid    = 1'b0;
  assign bus.log_addr     = 32'd0;
  assign bus.log_data     = 32'd0;
  assign bus.log_overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_monitor
// Brief    : Directed and randomized checks of store_monitor against a
//            queue-based reference model (log checks follow STORE_MONITOR_LOG_EN).
// Revision : 1.0
// ============================================================================
module tb_store_monitor;
  localparam logic [31:0] P_PASS_ADDR = 32'd100;
  localparam logic [31:0] P_PASS_DATA = 32'd25;
  localparam logic [31:0] P_SCRATCH   = 32'd96;
  localparam int          P_TIMEOUT   = 50;
  localparam int          P_DEPTH     = 8;
`ifdef STORE_MONITOR_LOG_EN
  localparam bit c_log_en = 1'b1;
`else
  localparam bit c_log_en = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  store_monitor_if bus ();

  always #5 clk = ~clk;

  store_monitor #(
    .PASS_ADDR    (P_PASS_ADDR),
    .PASS_DATA    (P_PASS_DATA),
    .SCRATCH_ADDR (P_SCRATCH),
    .TIMEOUT      (P_TIMEOUT),
    .LOG_DEPTH    (P_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: state 0 = running, 1 = passed, 2 = failed.
  int          m_state;
  int          m_code;
  int unsigned m_cycles;
  int          m_stores;
  logic [63:0] m_log[$];
  bit          m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_code   = 0;
    m_cycles = 0;
    m_stores = 0;
    m_ovf    = 1'b0;
    m_log.delete();
  endtask

  task automatic model_step(input bit we, input logic [31:0] adr, input logic [31:0] data,
                            input bit pop);
    bit          pop_ok;
    int unsigned old_cycles;
    pop_ok = pop && (m_log.size() > 0);
    if (m_state == 0) begin
      old_cycles = m_cycles;
      m_cycles++;
      if (we) begin
        if (m_stores < 65535) m_stores++;
        if (c_log_en) begin
          if (m_log.size() - int'(pop_ok) < P_DEPTH) m_log.push_back({adr, data});
          else m_ovf = 1'b1;
        end
      end
      if (we && adr == P_PASS_ADDR) begin
        if (data == P_PASS_DATA) m_state = 1;
        else begin m_state = 2; m_code = 2; end
      end else if (we && adr != P_SCRATCH) begin
        m_state = 2; m_code = 1;
      end else if (old_cycles == P_TIMEOUT - 1) begin
        m_state = 2; m_code = 3;
      end
    end
    if (pop_ok) void'(m_log.pop_front());
  endtask

  task automatic check_outputs();
    logic [63:0] head;
    head = (m_log.size() > 0) ? m_log[0] : 64'd0;
    check("done",         bus.done,         m_state != 0);
    check("pass",         bus.pass,         m_state == 1);
    check("fail_code",    bus.fail_code,    m_code);
    check("cycle_count",  bus.cycle_count,  m_cycles);
    check("store_count",  bus.store_count,  m_stores);
    check("log_valid",    bus.log_valid,    m_log.size() > 0);
    check("log_addr",     bus.log_addr,     head[63:32]);
    check("log_data",     bus.log_data,     head[31:0]);
    check("log_overflow", bus.log_overflow, m_ovf);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input bit we, input logic [31:0] adr, input logic [31:0] data,
                       input bit pop);
    bus.MemWrite  = we;
    bus.DataAdr   = adr;
    bus.WriteData = data;
    bus.log_pop   = pop;
    @(posedge clk);
    if (reset) model_step(we, adr, data, pop);
    else model_reset();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  // Asserts reset between edges, checks the asynchronous clear, then holds it
  // over two edges with stores offered before releasing it on a falling edge.
  task automatic do_reset();
    #2;
    reset         = 1'b0;
    bus.MemWrite  = 1'b1;
    bus.DataAdr   = P_PASS_ADDR;
    bus.WriteData = P_PASS_DATA;
    #1;
    model_reset();
    check_outputs();
    cycle(1'b1, P_PASS_ADDR, P_PASS_DATA, 1'b1);
    cycle(1'b1, 32'd104, $urandom, 1'b0);
    reset        = 1'b1;
    bus.MemWrite = 1'b0;
    bus.log_pop  = 1'b0;
  endtask

  task automatic random_cycle();
    int          r;
    bit          we;
    logic [31:0] adr;
    logic [31:0] data;
    we   = ($urandom_range(99, 0) < 40);
    r    = $urandom_range(99, 0);
    data = $urandom;
    if (r < 82) adr = P_SCRATCH;
    else if (r < 92) begin
      adr = P_PASS_ADDR;
      if ($urandom_range(1, 0) == 1) data = P_PASS_DATA;
    end else adr = $urandom;
    cycle(we, adr, data, $urandom_range(99, 0) < 30);
  endtask

  initial begin
    bus.MemWrite  = 1'b0;
    bus.DataAdr   = '0;
    bus.WriteData = '0;
    bus.log_pop   = 1'b0;
    model_reset();
    @(negedge clk);

    // Scratch store then the pass store.
    do_reset();
    cycle(1'b1, 32'd96, 32'd7, 1'b0);
    check("s1_done_early", bus.done, 1'b0);
    cycle(1'b1, 32'd100, 32'd25, 1'b0);
    check("s1_pass", bus.pass, 1'b1);
    check("s1_stores", bus.store_count, 32'd2);

    // Reset in PASS, then a bad address followed by an ignored pass store.
    do_reset();
    check("s2_done_cleared", bus.done, 1'b0);
    cycle(1'b1, 32'd104, 32'd1, 1'b0);
    cycle(1'b1, 32'd100, 32'd25, 1'b0);
    check("s2_code", bus.fail_code, 32'd1);
    check("s2_pass", bus.pass, 1'b0);

    // Wrong pass data.
    do_reset();
    cycle(1'b1, 32'd100, 32'd24, 1'b0);
    check("s3_code", bus.fail_code, 32'd2);

    // Timeout with frozen cycle counter.
    do_reset();
    repeat (P_TIMEOUT + 5) cycle(1'b0, 32'd0, 32'd0, 1'b0);
    check("s4_code", bus.fail_code, 32'd3);
    check("s4_cycles", bus.cycle_count, P_TIMEOUT);

    // Overflow: nine stores with no pops, then drain.
    do_reset();
    for (int i = 0; i < P_DEPTH + 1; i++) cycle(1'b1, P_SCRATCH, 32'd1000 + i, 1'b0);
    repeat (P_DEPTH + 1) cycle(1'b0, 32'd0, 32'd0, 1'b1);

    // Full FIFO, then simultaneous store and pop, then drain.
    do_reset();
    for (int i = 0; i < P_DEPTH; i++) cycle(1'b1, P_SCRATCH, 32'd2000 + i, 1'b0);
    cycle(1'b1, P_SCRATCH, 32'd77, 1'b1);
    repeat (P_DEPTH + 1) cycle(1'b0, 32'd0, 32'd0, 1'b1);

    // Randomized runs.
    for (int run = 0; run < 20; run++) begin
      do_reset();
      repeat (60) random_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_monitor.md
STORE_MONITOR -- requirements
Module: store_monitor

Interface
REQ-001 Parameter PASS_ADDR, default 32'd100: store address that signals program completion.
REQ-002 Parameter PASS_DATA, default 32'd25: data value at PASS_ADDR that signals success.
REQ-003 Parameter SCRATCH_ADDR, default 32'd96: the only other address stores may legally target.
REQ-004 Parameter TIMEOUT, default 2000: the maximum number of RUN cycles before a timeout is declared.
REQ-005 Parameter LOG_DEPTH, default 8: the store-log FIFO depth, a power of two, at least 2.
REQ-006 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-low reset.
REQ-008 Port MemWrite, input, 1: store strobe from the core, one store per high cycle.
REQ-009 Port DataAdr, input, 32: the store address, valid while MemWrite is high.
REQ-010 Port WriteData, input, 32: the store data, valid while MemWrite is high.
REQ-011 Port done, output, 1: the verdict is reached; sticky until reset.
REQ-012 Port pass, output, 1: the verdict is success; meaningful only while done is high.
REQ-013 Port fail_code, output, 2: 0 = none, 1 = bad address, 2 = bad pass data, 3 = timeout.
REQ-014 Port cycle_count, output, 32: the number of RUN cycles elapsed.
REQ-015 Port store_count, output, 16: the number of accepted stores, saturating at 16'hFFFF.
REQ-016 Ports log_pop (in, 1), log_valid (out, 1), log_addr (out, 32), log_data (out, 32), log_overflow (out, 1): store-log read side.

Function
REQ-017 The FSM SHALL have three states, RUN, PASS and FAIL, and SHALL enter RUN on reset release.
REQ-018 In RUN, a cycle with MemWrite=1, DataAdr=PASS_ADDR and WriteData=PASS_DATA SHALL move the FSM to PASS.
REQ-019 In RUN, a cycle with MemWrite=1, DataAdr=PASS_ADDR and any other WriteData SHALL move the FSM to FAIL with fail_code=2.
REQ-020 In RUN, a cycle with MemWrite=1 and DataAdr equal to neither PASS_ADDR nor SCRATCH_ADDR SHALL move the FSM to FAIL with fail_code=1.
REQ-021 In RUN, when cycle_count reaches TIMEOUT-1 with no terminating store, the next edge SHALL move the FSM to FAIL with fail_code=3; a terminating store on that same cycle takes priority.
REQ-022 done, pass and fail_code SHALL be registered and valid on the first rising edge after the deciding store, giving one cycle of latency.
REQ-023 PASS and FAIL SHALL be absorbing: further stores are ignored and cycle_count freezes.
REQ-024 store_count SHALL increment once per MemWrite=1 cycle while in RUN, including the deciding store.
REQ-025 The log SHALL push {DataAdr, WriteData} on every store counted by store_count.
REQ-026 log_valid SHALL be high whenever the FIFO is non-empty, and log_addr/log_data SHALL show the oldest entry (first-word fall-through).
REQ-027 log_pop while log_valid is high SHALL remove the head entry; log_pop while log_valid is low SHALL be ignored.
REQ-028 A push and a pop in the same cycle SHALL succeed together, leaving the occupancy unchanged, including when the FIFO is full.
REQ-029 A push while the FIFO is full with no pop SHALL be dropped and SHALL set log_overflow, which is sticky until reset.
REQ-030 The FIFO read and write pointers SHALL wrap modulo LOG_DEPTH.

Reset
REQ-031 Asserting reset at any time, including mid-store or in PASS/FAIL, SHALL immediately force state=RUN, done=0, pass=0, fail_code=0, cycle_count=0, store_count=0, the log empty, log_valid=0, log_addr=0, log_data=0 and log_overflow=0.
REQ-032 While reset is low, MemWrite SHALL be ignored.

Configuration
REQ-033 With macro STORE_MONITOR_LOG_EN defined, the FIFO log (REQ-025 to REQ-030) SHALL be compiled in.
REQ-034 Without STORE_MONITOR_LOG_EN, no FIFO storage SHALL exist, log_valid, log_addr, log_data and log_overflow SHALL be tied to 0, and log_pop SHALL be ignored; all other behaviour is unchanged.

Verification
REQ-035 Bench: stores (96, 7) then (100, 25) -> done=1, pass=1, fail_code=0 one edge after the second store; store_count=2.
REQ-036 Bench: store (104, 1) -> done=1, pass=0, fail_code=1; a later store (100, 25) changes nothing.
REQ-037 Bench: store (100, 24) -> fail_code=2; with TIMEOUT=50 and no stores -> fail_code=3 with cycle_count=50 frozen.
REQ-038 Bench (LOG_EN): 9 stores to 96 with no pops at LOG_DEPTH=8 -> log_overflow=1 and 8 entries popped in order, with data equal to the first 8 stores.
REQ-039 Bench (LOG_EN): FIFO full, then a simultaneous store and pop -> log_overflow stays 0 and the occupancy stays at 8.
REQ-040 Bench: reset pulsed low in PASS -> all outputs return to 0 asynchronously, and the monitor re-runs correctly afterwards.
